// File: rtl/mul_pipe_ctrl.sv
// mul_pipe_ctrl: control and writeback stage around the LATENCY-deep multiply unit.
// Carries {valid, op, tag} through a shift pipeline that matches the multiplier
// depth, so the op select leaves the pipeline together with its product. The
// selected result is captured in a one-entry writeback buffer with a valid/ready
// handshake toward the result bus.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   issue_valid_i/ready_o, issue_op_i, issue_tag_i   multiply request handshake
//   flush_i              kill all in-flight and buffered operations
//   mul_clk_en_o         multiplier clock enable (pipeline advance)
//   mul_ops_o            op select for the multiplier output mux, aligned with the product
//   mul_result_i         selected multiplier result
//   wb_valid_o/ready_i, wb_tag_o, wb_result_o        writeback entry handshake
//   busy_o               any stage or the buffer holds a valid entry
module mul_pipe_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [1:0]       issue_op_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             flush_i,
    output logic             mul_clk_en_o,
    output logic [1:0]       mul_ops_o,
    input  logic [XLEN-1:0]  mul_result_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [XLEN-1:0]  wb_result_o,
    output logic             busy_o
);

    localparam int unsigned OP_W = 2;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("mul_pipe_ctrl: LATENCY must be in 1..8");
    end

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic               en;
    logic [LATENCY-1:0] s_valid;
    logic [LATENCY-1:0] v_next;
    stage_t             s_data [LATENCY];
    stage_t             d_next [LATENCY];

    // The whole pipe moves only when the buffer is empty or being drained.
    assign en            = !wb_valid_o || wb_ready_i;
    assign mul_clk_en_o  = en;
    assign issue_ready_o = en;
    assign mul_ops_o     = s_data[LATENCY-1].op;
    assign busy_o        = (|s_valid) || wb_valid_o;

    // Shifted view of the pipeline: stage 0 takes the issue, stage k takes stage k-1.
    always_comb begin
        v_next    = '0;
        d_next    = '{default: '0};
        v_next[0] = issue_valid_i;
        d_next[0] = '{op: issue_op_i, tag: issue_tag_i};
        for (int k = 1; k < int'(LATENCY); k++) begin
            v_next[k] = s_valid[k-1];
            d_next[k] = s_data[k-1];
        end
    end

    // Stage valids: flush wins over advance and stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_valid <= '0;
        end else if (flush_i) begin
            s_valid <= '0;
        end else if (en) begin
            s_valid <= v_next;
        end
    end

    // Stage payloads are never cleared by flush; stale payload is harmless once its valid is gone.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                s_data[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                s_data[k] <= d_next[k];
            end
        end
    end

    // Writeback buffer; drain and refill in the same edge leaves no bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_valid_o  <= 1'b0;
            wb_tag_o    <= '0;
            wb_result_o <= '0;
        end else begin
            if (flush_i) begin
                wb_valid_o <= 1'b0;
            end else if (en) begin
                wb_valid_o <= s_valid[LATENCY-1];
            end
            if (en) begin
                wb_tag_o <= s_data[LATENCY-1].tag;
                if (s_valid[LATENCY-1]) begin
                    wb_result_o <= mul_result_i;
                end
            end
        end
    end

endmodule
